dag_circ_top: RTL and testbench
===============================

Name: dag_circ_top

Overview:
Parametrised dual data address generator, successor to the single-bank DAG.
- Generator 0 drives data-memory addresses; generator 1 drives program-memory addresses.
- Each generator holds NREG index (I), modify (M), length (L) and base (B) registers.
- Supports post-modify, pre-modify, circular-buffer wrap and bit-reversed output.
- Sits between the program sequencer (ps_*) and the data bus (bc_*); addresses are registered toward the memories.

Parameters:
AW, 16, address/data width of every I/M/L/B register and of the output addresses
NREG, 8, registers of each type per generator (power of two, 2..16)
IW, $clog2(NREG), index field width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ps_dg_en  in  1  address generation request this cycle
ps_dg_dgsclt  in  1  generator select: 0 = DM (gen0), 1 = PM (gen1)
ps_dg_mdfy  in  1  1 = pre-modify (no I update), 0 = post-modify
ps_dg_brev  in  1  bit-reverse the output address
ps_dg_iadd  in  IW  I register index
ps_dg_madd  in  IW  M register index
ps_dg_wrt_en  in  1  register file write strobe
ps_dg_wrt_add  in  IW+3  write address: [IW+2:IW+1] type (00 M, 01 I, 10 L, 11 B), [IW] generator, [IW-1:0] index
ps_dg_rd_add  in  IW+3  read address, same encoding
bc_dt_out  in  AW  write data from bus
dg_dm_add  out  AW  registered DM address
dg_pm_add  out  AW  registered PM address
dg_dm_vld  out  1  dg_dm_add valid
dg_pm_vld  out  1  dg_pm_add valid
dg_bc_dt  out  AW  read data to bus (combinational)

Behaviour:
Synchronous reset (rst high at a clk edge):
- All I, M, L, B registers clear to 0.
- dg_dm_add and dg_pm_add clear to 0; dg_dm_vld and dg_pm_vld clear to 0.
- rst overrides any request or write issued in the same cycle.

Modify arithmetic:
- M is signed two's complement.
- sum = I + M, computed in AW+1 bits.
- If L == 0: linear; result = sum mod 2^AW.
- If L != 0 and M >= 0 and sum >= B+L: result = sum - L.
- If L != 0 and M < 0 and sum < B: result = sum + L.
- Wrap is applied once only; |M| < L is required, and behaviour is undefined otherwise.

Request (ps_dg_en=1), addressing the generator g = ps_dg_dgsclt:
- Post-modify (mdfy=0): raw address = I[g][iadd]; at the clk edge I[g][iadd] <= wrapped(I+M).
- Pre-modify (mdfy=1): raw address = wrapped(I+M); I is unchanged.
- If brev=1, the output address is raw with bit k swapped to bit AW-1-k.
- Latency: the address appears on dg_dm_add (g=0) or dg_pm_add (g=1) one cycle after the request, with the matching vld=1.
- The other generator's address holds its value and its vld is 0.
- If ps_dg_en=0, both vld go to 0 next cycle and the addresses hold.

Register write (ps_dg_wrt_en=1):
- The addressed register <= bc_dt_out at the clk edge.
- A write to B also loads the I register with the same generator/index with bc_dt_out.

Write/modify collisions:
- An explicit write to the I register being post-modified in the same cycle wins; the modify is discarded.
- A same-cycle write to the M, L or B used by a request does not affect that request, which uses the old values.

Read:
- dg_bc_dt = register selected by ps_dg_rd_add.
- If wrt_en=1 and wrt_add == rd_add, dg_bc_dt = bc_dt_out (bypass).
- A B write does not bypass to a read of the I register it loads.

Test Plan:
1. Linear post-modify: write I0(gen0)=0x0010, M0=0x0004, L0=0; 3 requests -> dg_dm_add 0x0010, 0x0014, 0x0018 on consecutive cycles, each 1 cycle after its request with dg_dm_vld=1; I0 ends at 0x001C.
2. Circular wrap: write B1(gen1)=0x0100 (I1 becomes 0x0100), L1=10, I1=0x0108, M1=3; post-modify request -> dg_pm_add=0x0108, I1=0x0101. Then M1=0xFFFD (-3), request -> dg_pm_add=0x0101, I1=0x0108.
3. Pre-modify and bit-reverse: I0=0x0001, M0=0x0001, mdfy=1, brev=1 -> dg_dm_add=0x4000; I0 stays 0x0001. mdfy=0, brev=1 -> dg_dm_add=0x8000.
4. Collision: I0=0x0020, M0=2, post-modify request plus same-cycle write I0=0x0055 -> dg_dm_add=0x0020, I0=0x0055.
5. Read bypass: read M3 (gen0) while writing M3=0xABCD -> dg_bc_dt=0xABCD that cycle. Next cycle, with wrt_en=0 -> dg_bc_dt=0xABCD from the register.
6. Reset mid-operation: issue continuous requests, assert rst for 1 cycle -> next cycle all vld=0, all addresses 0, all registers read back 0, with no update from the request issued in the rst cycle.

Source files
------------

// File: rtl/dag_circ_top.sv
// rtl/dag_circ_top.sv - dual data address generator with circular wrap and bit reversal
module dag_circ_top #(
  parameter int AW   = 16,
  parameter int NREG = 8,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic          ps_dg_brev,
  input  logic [IW-1:0] ps_dg_iadd,
  input  logic [IW-1:0] ps_dg_madd,
  input  logic          ps_dg_wrt_en,
  input  logic [IW+2:0] ps_dg_wrt_add,
  input  logic [IW+2:0] ps_dg_rd_add,
  input  logic [AW-1:0] bc_dt_out,
  output logic [AW-1:0] dg_dm_add,
  output logic [AW-1:0] dg_pm_add,
  output logic          dg_dm_vld,
  output logic          dg_pm_vld,
  output logic [AW-1:0] dg_bc_dt
);

  // register type field of the write/read address
  localparam logic [1:0] TYPE_M = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_L = 2'b10;
  localparam logic [1:0] TYPE_B = 2'b11;

  // per-generator register files: [generator][index]
  logic [AW-1:0] i_reg [2][NREG];
  logic [AW-1:0] m_reg [2][NREG];
  logic [AW-1:0] l_reg [2][NREG];
  logic [AW-1:0] b_reg [2][NREG];

  // request operands; L and B are paired with the I register being used
  logic          req_gen;
  logic [AW-1:0] cur_i;
  logic [AW-1:0] cur_m;
  logic [AW-1:0] cur_l;
  logic [AW-1:0] cur_b;

  assign req_gen = ps_dg_dgsclt;
  assign cur_i   = i_reg[req_gen][ps_dg_iadd];
  assign cur_m   = m_reg[req_gen][ps_dg_madd];
  assign cur_l   = l_reg[req_gen][ps_dg_iadd];
  assign cur_b   = b_reg[req_gen][ps_dg_iadd];

  // wide signed copies so the wrap compares see the true (unwrapped) sum
  logic signed [AW+1:0] sum_s;
  logic signed [AW+1:0] b_s;
  logic signed [AW+1:0] bl_s;
  logic                 m_neg;
  logic                 wrap_dn;
  logic                 wrap_up;

  assign sum_s = $signed({2'b00, cur_i}) + $signed({{2{cur_m[AW-1]}}, cur_m});
  assign b_s   = $signed({2'b00, cur_b});
  assign bl_s  = $signed({2'b00, cur_b}) + $signed({2'b00, cur_l});
  assign m_neg = cur_m[AW-1];

  // wrap decision: forward past the buffer end or backward below its base
  always_comb begin
    wrap_dn = 1'b0;
    wrap_up = 1'b0;
    if (cur_l != '0) begin
      if (!m_neg && (sum_s >= bl_s)) begin
        wrap_dn = 1'b1;
      end
      if (m_neg && (sum_s < b_s)) begin
        wrap_up = 1'b1;
      end
    end
  end

  // modular result: the low AW bits of the wide arithmetic are all that survive
  logic [AW-1:0] lin_sum;
  logic [AW-1:0] mod_res;

  assign lin_sum = cur_i + cur_m;

  // apply the single wrap correction to the linear sum
  always_comb begin
    mod_res = lin_sum;
    if (wrap_dn) begin
      mod_res = lin_sum - cur_l;
    end else if (wrap_up) begin
      mod_res = lin_sum + cur_l;
    end
  end

  // raw address before optional bit reversal
  logic [AW-1:0] raw_addr;
  logic [AW-1:0] rev_addr;
  logic [AW-1:0] out_addr;

  assign raw_addr = ps_dg_mdfy ? mod_res : cur_i;

  for (genvar k = 0; k < AW; k++) begin : g_brev
    assign rev_addr[k] = raw_addr[AW-1-k];
  end

  assign out_addr = ps_dg_brev ? rev_addr : raw_addr;

  // write address decode
  logic [1:0]    wr_type;
  logic          wr_gen;
  logic [IW-1:0] wr_idx;

  assign wr_type = ps_dg_wrt_add[IW+2:IW+1];
  assign wr_gen  = ps_dg_wrt_add[IW];
  assign wr_idx  = ps_dg_wrt_add[IW-1:0];

  // register file update: post-modify first, explicit writes last so they win
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        for (int n = 0; n < NREG; n++) begin
          i_reg[g][n] <= '0;
          m_reg[g][n] <= '0;
          l_reg[g][n] <= '0;
          b_reg[g][n] <= '0;
        end
      end
    end else begin
      if (ps_dg_en && !ps_dg_mdfy) begin
        i_reg[req_gen][ps_dg_iadd] <= mod_res;
      end
      if (ps_dg_wrt_en) begin
        case (wr_type)
          TYPE_M: m_reg[wr_gen][wr_idx] <= bc_dt_out;
          TYPE_I: i_reg[wr_gen][wr_idx] <= bc_dt_out;
          TYPE_L: l_reg[wr_gen][wr_idx] <= bc_dt_out;
          TYPE_B: begin
            b_reg[wr_gen][wr_idx] <= bc_dt_out;
            i_reg[wr_gen][wr_idx] <= bc_dt_out;
          end
          default: ;
        endcase
      end
    end
  end

  // registered address outputs; the idle generator holds its address
  always_ff @(posedge clk) begin
    if (rst) begin
      dg_dm_add <= '0;
      dg_pm_add <= '0;
      dg_dm_vld <= 1'b0;
      dg_pm_vld <= 1'b0;
    end else begin
      dg_dm_vld <= ps_dg_en && !req_gen;
      dg_pm_vld <= ps_dg_en && req_gen;
      if (ps_dg_en && !req_gen) begin
        dg_dm_add <= out_addr;
      end
      if (ps_dg_en && req_gen) begin
        dg_pm_add <= out_addr;
      end
    end
  end

  // read address decode
  logic [1:0]    rd_type;
  logic          rd_gen;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] rd_reg;

  assign rd_type = ps_dg_rd_add[IW+2:IW+1];
  assign rd_gen  = ps_dg_rd_add[IW];
  assign rd_idx  = ps_dg_rd_add[IW-1:0];

  // register read mux
  always_comb begin
    rd_reg = '0;
    case (rd_type)
      TYPE_M:  rd_reg = m_reg[rd_gen][rd_idx];
      TYPE_I:  rd_reg = i_reg[rd_gen][rd_idx];
      TYPE_L:  rd_reg = l_reg[rd_gen][rd_idx];
      TYPE_B:  rd_reg = b_reg[rd_gen][rd_idx];
      default: rd_reg = '0;
    endcase
  end

  // exact-address bypass only; a B write does not forward to the I it loads
  always_comb begin
    dg_bc_dt = rd_reg;
    if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) begin
      dg_bc_dt = bc_dt_out;
    end
  end

endmodule

// File: tb/tb_dag_circ_top.sv
// tb/tb_dag_circ_top.sv - randomized and directed bench for dag_circ_top
module tb_dag_circ_top;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sel;
  logic        mdfy;
  logic        brev;
  logic [2:0]  iadd;
  logic [2:0]  madd;
  logic        wrt_en;
  logic [5:0]  wrt_add;
  logic [5:0]  rd_add;
  logic [15:0] bc_dt_out;
  logic [15:0] dg_dm_add;
  logic [15:0] dg_pm_add;
  logic        dg_dm_vld;
  logic        dg_pm_vld;
  logic [15:0] dg_bc_dt;

  int total;
  int bad;

  // reference state: type 0=M 1=I 2=L 3=B
  int mreg [4][2][8];
  int exp_dm;
  int exp_pm;
  int exp_dmv;
  int exp_pmv;

  dag_circ_top #(.AW(16), .NREG(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps_dg_en     (en),
    .ps_dg_dgsclt (sel),
    .ps_dg_mdfy   (mdfy),
    .ps_dg_brev   (brev),
    .ps_dg_iadd   (iadd),
    .ps_dg_madd   (madd),
    .ps_dg_wrt_en (wrt_en),
    .ps_dg_wrt_add(wrt_add),
    .ps_dg_rd_add (rd_add),
    .bc_dt_out    (bc_dt_out),
    .dg_dm_add    (dg_dm_add),
    .dg_pm_add    (dg_pm_add),
    .dg_dm_vld    (dg_dm_vld),
    .dg_pm_vld    (dg_pm_vld),
    .dg_bc_dt     (dg_bc_dt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // circular-buffer address arithmetic with plain integers
  function automatic int next_addr(int i, int m_raw, int l, int b);
    int m;
    int s;
    m = (m_raw >= 32768) ? m_raw - 65536 : m_raw;
    s = i + m;
    if (l != 0) begin
      if (m >= 0 && s >= b + l) s = s - l;
      else if (m < 0 && s < b) s = s + l;
    end
    return ((s % 65536) + 65536) % 65536;
  endfunction

  function automatic int bit_rev(int a);
    int r;
    r = 0;
    for (int k = 0; k < 16; k++) begin
      if (((a >> k) & 1) != 0) r = r | (1 << (15 - k));
    end
    return r;
  endfunction

  function automatic int exp_read();
    int t;
    int g;
    int n;
    t = int'(rd_add[5:4]);
    g = int'(rd_add[3]);
    n = int'(rd_add[2:0]);
    if (wrt_en && wrt_add == rd_add) return int'(bc_dt_out);
    return mreg[t][g][n];
  endfunction

  // advance one clock, updating the reference from the driven inputs
  task automatic step();
    int g;
    int ia;
    int res;
    int raw;
    int addr;
    if (rst) begin
      for (int t = 0; t < 4; t++)
        for (int gg = 0; gg < 2; gg++)
          for (int n = 0; n < 8; n++) mreg[t][gg][n] = 0;
      exp_dm = 0; exp_pm = 0; exp_dmv = 0; exp_pmv = 0;
    end else begin
      exp_dmv = 0;
      exp_pmv = 0;
      if (en) begin
        g = int'(sel);
        ia = int'(iadd);
        res = next_addr(mreg[1][g][ia], mreg[0][g][int'(madd)], mreg[2][g][ia], mreg[3][g][ia]);
        raw = mdfy ? res : mreg[1][g][ia];
        addr = brev ? bit_rev(raw) : raw;
        if (!mdfy) mreg[1][g][ia] = res;
        if (g == 0) begin exp_dm = addr; exp_dmv = 1; end
        else begin exp_pm = addr; exp_pmv = 1; end
      end
      if (wrt_en) begin
        mreg[int'(wrt_add[5:4])][int'(wrt_add[3])][int'(wrt_add[2:0])] = int'(bc_dt_out);
        if (wrt_add[5:4] == 2'b11) mreg[1][int'(wrt_add[3])][int'(wrt_add[2:0])] = int'(bc_dt_out);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int t, input int g, input int n, input int v);
    wrt_en = 1'b1;
    wrt_add = 6'((t << 4) | (g << 3) | n);
    bc_dt_out = 16'(v);
    step();
    wrt_en = 1'b0;
  endtask

  task automatic req(input int g, input int md, input int br, input int ia, input int ma);
    en = 1'b1; sel = 1'(g); mdfy = 1'(md); brev = 1'(br);
    iadd = 3'(ia); madd = 3'(ma);
    step();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (dg_dm_vld !== 1'b0 || dg_pm_vld !== 1'b0) begin
      bad++; $display("FAIL reset_vld got dm=%0b pm=%0b want 0 0", dg_dm_vld, dg_pm_vld);
    end
    total++;
    if (dg_dm_add !== 16'h0 || dg_pm_add !== 16'h0) begin
      bad++; $display("FAIL reset_addr got dm=%h pm=%h want 0 0", dg_dm_add, dg_pm_add);
    end
    rd_add = 6'b010101; #1;
    total++;
    if (dg_bc_dt !== 16'h0) begin
      bad++; $display("FAIL reset_read got %h want 0000", dg_bc_dt);
    end
  endtask

  task automatic test_linear();
    int want [3];
    want[0] = 'h10; want[1] = 'h14; want[2] = 'h18;
    wr(1, 0, 0, 'h10);
    wr(0, 0, 0, 'h4);
    en = 1'b1; sel = 1'b0; mdfy = 1'b0; brev = 1'b0; iadd = 3'd0; madd = 3'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (dg_dm_add !== 16'(want[k]) || dg_dm_vld !== 1'b1 || dg_pm_vld !== 1'b0) begin
        bad++; $display("FAIL linear_%0d got add=%h vld=%0b pmv=%0b want %h 1 0", k, dg_dm_add, dg_dm_vld, dg_pm_vld, want[k]);
      end
    end
    en = 1'b0;
    step();
    total++;
    if (dg_dm_vld !== 1'b0 || dg_dm_add !== 16'h18) begin
      bad++; $display("FAIL linear_idle got add=%h vld=%0b want 0018 0", dg_dm_add, dg_dm_vld);
    end
    rd_add = 6'b010000; #1;
    total++;
    if (dg_bc_dt !== 16'h1C) begin
      bad++; $display("FAIL linear_i0 got %h want 001c", dg_bc_dt);
    end
  endtask

  task automatic test_circular();
    wr(3, 1, 1, 'h100);
    rd_add = 6'b011001; #1;
    total++;
    if (dg_bc_dt !== 16'h100) begin
      bad++; $display("FAIL circ_bload got %h want 0100", dg_bc_dt);
    end
    wr(2, 1, 1, 10);
    wr(1, 1, 1, 'h108);
    wr(0, 1, 1, 3);
    req(1, 0, 0, 1, 1);
    total++;
    if (dg_pm_add !== 16'h108 || dg_pm_vld !== 1'b1 || dg_dm_vld !== 1'b0 || dg_dm_add !== 16'h18) begin
      bad++; $display("FAIL circ_fwd got pm=%h pv=%0b dv=%0b dm=%h want 0108 1 0 0018", dg_pm_add, dg_pm_vld, dg_dm_vld, dg_dm_add);
    end
    rd_add = 6'b011001; #1;
    total++;
    if (dg_bc_dt !== 16'h101) begin
      bad++; $display("FAIL circ_fwd_i got %h want 0101", dg_bc_dt);
    end
    wr(0, 1, 1, 'hFFFD);
    req(1, 0, 0, 1, 1);
    total++;
    if (dg_pm_add !== 16'h101 || dg_pm_vld !== 1'b1) begin
      bad++; $display("FAIL circ_back got pm=%h vld=%0b want 0101 1", dg_pm_add, dg_pm_vld);
    end
    rd_add = 6'b011001; #1;
    total++;
    if (dg_bc_dt !== 16'h108) begin
      bad++; $display("FAIL circ_back_i got %h want 0108", dg_bc_dt);
    end
  endtask

  task automatic test_premod_brev();
    wr(1, 0, 0, 1);
    wr(0, 0, 0, 1);
    req(0, 1, 1, 0, 0);
    total++;
    if (dg_dm_add !== 16'h4000) begin
      bad++; $display("FAIL premod_brev got %h want 4000", dg_dm_add);
    end
    rd_add = 6'b010000; #1;
    total++;
    if (dg_bc_dt !== 16'h1) begin
      bad++; $display("FAIL premod_i got %h want 0001", dg_bc_dt);
    end
    req(0, 0, 1, 0, 0);
    total++;
    if (dg_dm_add !== 16'h8000) begin
      bad++; $display("FAIL postmod_brev got %h want 8000", dg_dm_add);
    end
  endtask

  task automatic test_collision();
    wr(1, 0, 0, 'h20);
    wr(0, 0, 0, 2);
    wrt_en = 1'b1; wrt_add = 6'b010000; bc_dt_out = 16'h55;
    req(0, 0, 0, 0, 0);
    wrt_en = 1'b0;
    total++;
    if (dg_dm_add !== 16'h20) begin
      bad++; $display("FAIL collide_addr got %h want 0020", dg_dm_add);
    end
    rd_add = 6'b010000; #1;
    total++;
    if (dg_bc_dt !== 16'h55) begin
      bad++; $display("FAIL collide_i got %h want 0055", dg_bc_dt);
    end
  endtask

  task automatic test_bypass();
    wrt_en = 1'b1; wrt_add = 6'b000011; bc_dt_out = 16'hABCD;
    rd_add = 6'b000011; #1;
    total++;
    if (dg_bc_dt !== 16'hABCD) begin
      bad++; $display("FAIL bypass_now got %h want abcd", dg_bc_dt);
    end
    step();
    wrt_en = 1'b0; #1;
    total++;
    if (dg_bc_dt !== 16'hABCD) begin
      bad++; $display("FAIL bypass_reg got %h want abcd", dg_bc_dt);
    end
  endtask

  task automatic test_random();
    int t;
    int v;
    int er;
    // keep every |M| below any nonzero L so wrap stays well defined
    for (int g = 0; g < 2; g++)
      for (int n = 0; n < 8; n++) wr(0, g, n, (int'($urandom_range(0, 14)) - 7) & 'hFFFF);
    for (int c = 0; c < 400; c++) begin
      en = 1'($urandom_range(0, 3) != 0);
      sel = 1'($urandom_range(0, 1));
      mdfy = 1'($urandom_range(0, 1));
      brev = 1'($urandom_range(0, 3) == 0);
      iadd = 3'($urandom_range(0, 7));
      madd = 3'($urandom_range(0, 7));
      wrt_en = 1'($urandom_range(0, 2) == 0);
      t = int'($urandom_range(0, 3));
      if (t == 0) v = (int'($urandom_range(0, 14)) - 7) & 'hFFFF;
      else if (t == 2) v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(8, 40));
      else v = int'($urandom & 32'hFFFF);
      wrt_add = 6'((t << 4) | int'($urandom_range(0, 15)));
      bc_dt_out = 16'(v);
      rd_add = ($urandom_range(0, 3) == 0) ? wrt_add : 6'($urandom_range(0, 63));
      #1;
      er = exp_read();
      total++;
      if (dg_bc_dt !== 16'(er)) begin
        bad++; $display("FAIL rand_read c=%0d got %h want %h", c, dg_bc_dt, 16'(er));
      end
      step();
      total++;
      if (dg_dm_add !== 16'(exp_dm) || dg_pm_add !== 16'(exp_pm) ||
          dg_dm_vld !== 1'(exp_dmv) || dg_pm_vld !== 1'(exp_pmv)) begin
        bad++; $display("FAIL rand_addr c=%0d got dm=%h/%0b pm=%h/%0b want %h/%0d %h/%0d",
                        c, dg_dm_add, dg_dm_vld, dg_pm_add, dg_pm_vld, 16'(exp_dm), exp_dmv, 16'(exp_pm), exp_pmv);
      end
    end
    en = 1'b0;
    wrt_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; sel = 1'b0; mdfy = 1'b0; brev = 1'b0; iadd = 3'd0; madd = 3'd0;
    wr(1, 0, 0, 'h30);
    en = 1'b1; sel = 1'b1;
    step();
    rst = 1'b1;
    wrt_en = 1'b1; wrt_add = 6'b010000; bc_dt_out = 16'h77;
    step();
    rst = 1'b0; en = 1'b0; wrt_en = 1'b0;
    total++;
    if (dg_dm_vld !== 1'b0 || dg_pm_vld !== 1'b0 || dg_dm_add !== 16'h0 || dg_pm_add !== 16'h0) begin
      bad++; $display("FAIL rstmid_out got dm=%h/%0b pm=%h/%0b want 0/0 0/0", dg_dm_add, dg_dm_vld, dg_pm_add, dg_pm_vld);
    end
    for (int a = 0; a < 64; a++) begin
      rd_add = 6'(a); #1;
      total++;
      if (dg_bc_dt !== 16'h0) begin
        bad++; $display("FAIL rstmid_reg a=%0d got %h want 0000", a, dg_bc_dt);
      end
      step();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; en = 1'b0; sel = 1'b0; mdfy = 1'b0; brev = 1'b0;
    iadd = 3'd0; madd = 3'd0; wrt_en = 1'b0; wrt_add = 6'd0; rd_add = 6'd0; bc_dt_out = 16'd0;
    exp_dm = 0; exp_pm = 0; exp_dmv = 0; exp_pmv = 0;
    #2;
    test_reset();
    test_linear();
    test_circular();
    test_premod_brev();
    test_collision();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
